// File: rtl/sigmoid_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sigmoid_pkg
//  Brief    : Shared Q8.8 constants and the piecewise-quadratic sigmoid rule
//             used by the sigmoid_arbiter pipeline.
//  Revision : 1.0 - initial release
// ============================================================================
package sigmoid_pkg;

    localparam int ONE_Q88  = 256;
    localparam int HALF_Q88 = 128;
    localparam int SIG_BIAS = 16;

    typedef logic [7:0]  operand_t;
    typedef logic [15:0] q88_t;

    // Saturating branches catch x=-128, so the quadratic path only ever sees |x| < sat_lim.
    function automatic q88_t sigmoid_q88(input operand_t x, input int sat_lim);
        logic [7:0]         y;
        logic [7:0]         z;
        logic signed [7:0]  s;
        logic signed [15:0] s16;
        logic [15:0]        q;
        logic [15:0]        h;
        q88_t               r;
        y   = '0;
        z   = '0;
        s   = '0;
        s16 = '0;
        q   = '0;
        h   = '0;
        if (int'($signed(x)) >= sat_lim) begin
            r = 16'(ONE_Q88);
        end else if (int'($signed(x)) <= -sat_lim) begin
            r = '0;
        end else begin
            y   = x[7] ? (~x + 8'd1) : x;
            z   = y >> 2;
            s   = $signed(z - 8'(SIG_BIAS));
            s16 = 16'(s);
            q   = 16'(s16 * s16);
            h   = q >> 1;
            r   = x[7] ? h : (16'(ONE_Q88) - h);
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sigmoid_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : sigmoid_rr_pick
//  Brief    : Round-robin one-hot pick; scans upward from ptr, wrapping to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module sigmoid_rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic            any
);

    // First pass covers ptr..NREQ-1, second pass the wrapped range 0..ptr-1.
    always_comb begin
        gnt = '0;
        any = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!any && req[i] && (i >= int'(ptr))) begin
                gnt[i] = 1'b1;
                any    = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!any && req[i] && (i < int'(ptr))) begin
                gnt[i] = 1'b1;
                any    = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sigmoid_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sigmoid_arbiter
//  Brief    : NREQ requesters share a 2-stage sigmoid pipeline through a
//             round-robin arbiter with downstream valid/ready backpressure.
//  Revision : 1.0 - initial release
// ============================================================================
module sigmoid_arbiter
    import sigmoid_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int SAT_LIM = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*8-1:0]        req_x,
    output logic [NREQ-1:0]          req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [15:0]              rsp_data,
    output logic [15:0]              xfer_count
);

    localparam int IDW = $clog2(NREQ);

    logic [7:0]      w_x [NREQ];
    logic [NREQ-1:0] w_pick;
    logic            w_any;
    logic [IDW-1:0]  w_gidx;
    logic [7:0]      w_sel_x;
    logic            w_s2_load;
    logic            w_grant_en;
    logic            w_take;
    q88_t            w_s1_result;

    logic            r_s1_valid;
    logic [7:0]      r_s1_x;
    logic [IDW-1:0]  r_s1_id;
    logic            r_s2_valid;
    q88_t            r_s2_data;
    logic [IDW-1:0]  r_s2_id;
    logic [IDW-1:0]  r_ptr;
    logic [15:0]     r_xfer_count;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
            assign w_x[gi] = req_x[8*gi +: 8];
        end
    endgenerate

    sigmoid_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req  (req_valid),
        .ptr  (r_ptr),
        .gnt  (w_pick),
        .any  (w_any)
    );

    // S1 may accept a new operand when it is empty or is moving into S2 this cycle.
    assign w_s2_load  = !r_s2_valid || rsp_ready;
    assign w_grant_en = !rst && (!r_s1_valid || w_s2_load);
    assign w_take     = w_grant_en && w_any;
    assign req_ready  = w_grant_en ? w_pick : '0;

    always_comb begin
        w_gidx  = '0;
        w_sel_x = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_pick[i]) begin
                w_gidx  = IDW'(i);
                w_sel_x = w_x[i];
            end
        end
    end

    assign w_s1_result = sigmoid_q88(r_s1_x, SAT_LIM);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid   <= 1'b0;
            r_s1_x       <= '0;
            r_s1_id      <= '0;
            r_s2_valid   <= 1'b0;
            r_s2_data    <= '0;
            r_s2_id      <= '0;
            r_ptr        <= '0;
            r_xfer_count <= '0;
        end else begin
            if (w_take) begin
                r_s1_valid <= 1'b1;
                r_s1_x     <= w_sel_x;
                r_s1_id    <= w_gidx;
                r_ptr      <= (w_gidx == IDW'(NREQ-1)) ? '0 : (w_gidx + IDW'(1));
            end else if (w_s2_load) begin
                r_s1_valid <= 1'b0;
            end

            if (w_s2_load) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_data <= w_s1_result;
                    r_s2_id   <= r_s1_id;
                end
            end

            if (r_s2_valid && rsp_ready) begin
                r_xfer_count <= r_xfer_count + 16'd1;
            end
        end
    end

    assign rsp_valid  = r_s2_valid;
    assign rsp_data   = r_s2_data;
    assign rsp_id     = r_s2_id;
    assign xfer_count = r_xfer_count;

endmodule
`default_nettype wire

// File: tb/tb_sigmoid_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sigmoid_arbiter
//  Brief    : Self-checking bench for sigmoid_arbiter (directed + random).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sigmoid_arbiter;

    localparam int NREQ    = 4;
    localparam int SAT_LIM = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_x;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_data;
    logic [15:0] xfer_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int id;
        int d;
        int g;
    } item_t;

    sigmoid_arbiter #(
        .NREQ    (NREQ),
        .SAT_LIM (SAT_LIM)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_x      (req_x),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    function automatic int ref_sig(int x);
        int z;
        int h;
        if (x >= SAT_LIM) return 256;
        if (x <= -SAT_LIM) return 0;
        z = (x < 0 ? -x : x) / 4;
        h = ((z - 16) * (z - 16)) / 2;
        return (x < 0) ? h : 256 - h;
    endfunction

    function automatic int rr_ref(logic [3:0] v, int p);
        for (int k = 0; k < 4; k++) begin
            if (v[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '1;
        req_x = $urandom;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL reset_ready got=%b want=0000", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
        checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL reset_rsp_id got=%0d want=0", rsp_id); end
        checks++; if (rsp_data !== 16'd0) begin failures++; $display("FAIL reset_rsp_data got=%0d want=0", rsp_data); end
        checks++; if (xfer_count !== 16'd0) begin failures++; $display("FAIL reset_xfer_count got=%0d want=0", xfer_count); end
        @(negedge clk);
        rst = 1'b0;
        req_valid = '0;
    endtask

    task automatic test_single_operand();
        int xs [3] = '{0, 32, -32};
        int ex [3] = '{128, 224, 32};
        rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            req_valid = 4'b0100;
            req_x[23:16] = 8'(xs[k]);
            #1;
            checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL single_grant x=%0d got=%b want=0100", xs[k], req_ready); end
            @(negedge clk);
            req_valid = '0;
            #1;
            checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_early x=%0d got=%b want=0", xs[k], rsp_valid); end
            @(negedge clk);
            #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 16'(ex[k])) begin
                failures++;
                $display("FAIL single_result x=%0d got v=%b id=%0d d=%0d want v=1 id=2 d=%0d", xs[k], rsp_valid, rsp_id, rsp_data, ex[k]);
            end
        end
    endtask

    task automatic test_saturation();
        int xs [4] = '{64, 127, -64, -128};
        int ex [4] = '{256, 256, 0, 0};
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            req_valid = 4'(1 << k);
            req_x[8*k +: 8] = 8'(xs[k]);
            #1;
            @(negedge clk);
            req_valid = '0;
            @(negedge clk);
            #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'(k) || rsp_data !== 16'(ex[k])) begin
                failures++;
                $display("FAIL saturation x=%0d got v=%b id=%0d d=%0d want v=1 id=%0d d=%0d", xs[k], rsp_valid, rsp_id, rsp_data, k, ex[k]);
            end
        end
    endtask

    task automatic test_round_robin();
        int lx [4];
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            lx[i] = -40 + 25 * i;
            req_x[8*i +: 8] = 8'(lx[i]);
        end
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            req_valid = (k < 5) ? 4'b1111 : 4'b0000;
            rsp_ready = 1'b1;
            #1;
            if (k < 5) begin
                checks++;
                if (req_ready !== 4'(1 << (k % 4))) begin
                    failures++;
                    $display("FAIL rr_order cycle=%0d got=%b want=%b", k, req_ready, 4'(1 << (k % 4)));
                end
            end
            if (k >= 2) begin
                checks++;
                if (rsp_valid !== 1'b1 || rsp_id !== 2'((k - 2) % 4) || rsp_data !== 16'(ref_sig(lx[(k - 2) % 4]))) begin
                    failures++;
                    $display("FAIL rr_result cycle=%0d got v=%b id=%0d d=%0d want v=1 id=%0d d=%0d", k, rsp_valid, rsp_id, rsp_data, (k - 2) % 4, ref_sig(lx[(k - 2) % 4]));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int lx [4];
        int exp_id [$];
        int exp_d [$];
        int grants = 0;
        int got = 0;
        bit have = 1'b0;
        logic [15:0] held = '0;
        for (int i = 0; i < 4; i++) begin
            lx[i] = int'($urandom_range(0, 126)) - 63;
            req_x[8*i +: 8] = 8'(lx[i]);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            req_valid = 4'b1111;
            rsp_ready = 1'b0;
            #1;
            for (int i = 0; i < 4; i++) begin
                if (req_ready[i]) begin
                    grants++;
                    exp_id.push_back(i);
                    exp_d.push_back(ref_sig(lx[i]));
                end
            end
            if (rsp_valid === 1'b1) begin
                if (!have) begin
                    held = rsp_data;
                    have = 1'b1;
                end else begin
                    checks++;
                    if (rsp_data !== held) begin failures++; $display("FAIL bp_stable cycle=%0d got=%0d want=%0d", k, rsp_data, held); end
                end
            end
        end
        checks++; if (grants != 2) begin failures++; $display("FAIL bp_grants got=%0d want=2", grants); end
        checks++; if (!have) begin failures++; $display("FAIL bp_rsp_present got=0 want=1"); end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            req_valid = '0;
            rsp_ready = 1'b1;
            #1;
            if (rsp_valid === 1'b1) begin
                got++;
                checks++;
                if (exp_id.size() == 0) begin
                    failures++;
                    $display("FAIL bp_duplicate got id=%0d d=%0d want none", rsp_id, rsp_data);
                end else begin
                    if (rsp_id !== 2'(exp_id[0]) || rsp_data !== 16'(exp_d[0])) begin
                        failures++;
                        $display("FAIL bp_drain got id=%0d d=%0d want id=%0d d=%0d", rsp_id, rsp_data, exp_id[0], exp_d[0]);
                    end
                    void'(exp_id.pop_front());
                    void'(exp_d.pop_front());
                end
            end
        end
        checks++; if (got != 2) begin failures++; $display("FAIL bp_count got=%0d want=2", got); end
    endtask

    task automatic test_reset_inflight();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            req_valid = 4'b1111;
            rsp_ready = 1'b0;
        end
        @(negedge clk);
        rst = 1'b1;
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL rstmid_ready got=%b want=0000", req_ready); end
        @(negedge clk);
        rst = 1'b0;
        req_valid = 4'b1000;
        req_x[31:24] = 8'd20;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_data !== 16'd0 || xfer_count !== 16'd0) begin
            failures++;
            $display("FAIL rstmid_outputs got v=%b id=%0d d=%0d cnt=%0d want 0 0 0 0", rsp_valid, rsp_id, rsp_data, xfer_count);
        end
        checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL rstmid_first_grant got=%b want=1000", req_ready); end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_data !== 16'(ref_sig(20))) begin
            failures++;
            $display("FAIL rstmid_result got v=%b id=%0d d=%0d want v=1 id=3 d=%0d", rsp_valid, rsp_id, rsp_data, ref_sig(20));
        end
    endtask

    task automatic test_counter_wrap();
        bit seen = 1'b0;
        @(negedge clk);
        req_valid = '0;
        rsp_ready = 1'b1;
        force dut.r_xfer_count = 16'hFFFF;
        #1;
        release dut.r_xfer_count;
        #1;
        checks++; if (xfer_count !== 16'hFFFF) begin failures++; $display("FAIL wrap_preload got=%h want=ffff", xfer_count); end
        @(negedge clk);
        req_valid = 4'b0001;
        req_x[7:0] = 8'd5;
        @(negedge clk);
        req_valid = '0;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            #1;
            if (rsp_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++; if (!seen) begin failures++; $display("FAIL wrap_timeout got=no_rsp want=rsp"); end
        checks++; if (xfer_count !== 16'hFFFF) begin failures++; $display("FAIL wrap_before got=%h want=ffff", xfer_count); end
        @(negedge clk);
        #1;
        checks++; if (xfer_count !== 16'h0000) begin failures++; $display("FAIL wrap_after got=%h want=0000", xfer_count); end
    endtask

    task automatic test_random();
        item_t q [$];
        item_t it;
        int p = 0;
        int cnt = 0;
        int last_acc = -100;
        int g;
        int xv;
        bit exp_rv;
        logic [3:0] exp_rdy;
        pulse_reset();
        for (int now = 0; now < 400; now++) begin
            @(negedge clk);
            req_valid = 4'($urandom);
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 3) == 0) req_x[8*i +: 8] = 8'($urandom);
                else req_x[8*i +: 8] = 8'(int'($urandom_range(0, 140)) - 70);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_rv = (q.size() > 0) && (now >= q[0].g + 2) && (now >= last_acc + 1);
            checks++;
            if (rsp_valid !== exp_rv) begin
                failures++;
                $display("FAIL rnd_rsp_valid cycle=%0d got=%b want=%b", now, rsp_valid, exp_rv);
            end else if (exp_rv) begin
                checks++;
                if (rsp_id !== 2'(q[0].id) || rsp_data !== 16'(q[0].d)) begin
                    failures++;
                    $display("FAIL rnd_rsp cycle=%0d got id=%0d d=%0d want id=%0d d=%0d", now, rsp_id, rsp_data, q[0].id, q[0].d);
                end
            end
            checks++;
            if (xfer_count !== 16'(cnt)) begin failures++; $display("FAIL rnd_count cycle=%0d got=%0d want=%0d", now, xfer_count, cnt); end
            g = -1;
            if (req_valid != 4'b0 && !(q.size() == 2 && !rsp_ready)) g = rr_ref(req_valid, p);
            exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0;
            checks++;
            if (req_ready !== exp_rdy) begin failures++; $display("FAIL rnd_grant cycle=%0d got=%b want=%b", now, req_ready, exp_rdy); end
            if (exp_rv && rsp_ready) begin
                void'(q.pop_front());
                last_acc = now;
                cnt++;
            end
            if (g >= 0) begin
                xv = $signed(req_x[8*g +: 8]);
                it.id = g;
                it.d  = ref_sig(xv);
                it.g  = now;
                q.push_back(it);
                p = (g + 1) % 4;
            end
        end
        @(negedge clk);
        req_valid = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_x = '0;
        rsp_ready = 1'b1;
        test_reset();
        test_single_operand();
        test_saturation();
        test_round_robin();
        test_backpressure();
        test_reset_inflight();
        test_counter_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sigmoid_arbiter.md
SIGMOID_ARBITER -- requirements
Module: sigmoid_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the sigmoid datapath; legal range 2..8.
REQ-002 Parameter SAT_LIM, default 64: magnitude at or above which the input saturates.
REQ-003 Port clk, input, 1: single clock; all logic samples on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port req_valid, input, NREQ: per-requester operand valid.
REQ-006 Port req_x, input, NREQ*8: per-requester signed 8-bit operand; requester i occupies bits [8i+7:8i].
REQ-007 Port req_ready, output, NREQ: one-hot grant; requester i's transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-008 Port rsp_valid, output, 1: result valid.
REQ-009 Port rsp_ready, input, 1: downstream accepts the result.
REQ-010 Port rsp_id, output, clog2(NREQ): index of the requester that owns the result.
REQ-011 Port rsp_data, output, 16: signed Q8.8 sigmoid result.
REQ-012 Port xfer_count, output, 16: count of completed response transfers; wraps from 0xFFFF to 0.

Function
REQ-013 The block shall be a 2-stage pipeline: S1 holds the registered operand and id; S2 holds the registered result and id.
REQ-014 S2 shall load when S2 is empty or rsp_ready=1.
- S1 shall advance into S2 on exactly that condition.
- The arbiter may grant when S1 is empty or S1 advances in the same cycle.
REQ-015 At most one req_ready bit shall be high per cycle.
- req_ready shall depend combinationally on req_valid, the priority pointer and the pipeline state.
- req_ready[i] shall never be high while req_valid[i]=0.
REQ-016 Arbitration shall be round-robin.
- The search starts at pointer p and scans upward, wrapping from NREQ-1 to 0.
- After a grant to requester g, p shall become (g+1) mod NREQ.
- p shall be unchanged when no grant occurs.
REQ-017 Latency: a transfer at cycle N shall present rsp_valid=1 at cycle N+2 when rsp_ready stays high; full throughput is one result per cycle.
REQ-018 While rsp_valid=1 and rsp_ready=0:
- rsp_valid, rsp_id and rsp_data shall hold stable;
- S1 shall hold;
- no grant shall occur if S1 is full.
REQ-019 Result rule for input x:
- x >= SAT_LIM: result is 256.
- x <= -SAT_LIM: result is 0.
- Otherwise: y=|x|; z=y>>2; s=z-16 (signed 8-bit); q=s*s (16-bit); h=q>>1; result is h for x<0 and 256-h for x>=0.
REQ-020 The x=-128 case shall be covered by the saturation branch; the datapath shall never see |x|>=SAT_LIM.
REQ-021 xfer_count shall increment by 1 on each cycle where rsp_valid and rsp_ready are both high.
REQ-022 When a new grant and a downstream accept occur in the same cycle, both shall take effect with no bubble and no lost or duplicated result.

Reset
REQ-023 When rst=1 at a clock edge:
- S1 and S2 valid flags shall clear.
- rsp_valid=0, rsp_id=0, rsp_data=0.
- xfer_count=0 and p=0.
REQ-024 While rst=1, req_ready shall be all zeros.
REQ-025 Reset asserted mid-operation shall discard in-flight results; the first grant after reset release goes to the lowest-index valid requester.

Structure
REQ-026 A shared package sigmoid_pkg shall hold:
- the constants ONE_Q88=256, HALF_Q88=128 and the bias 16;
- the result rule as a function.
REQ-027 One sub-module, sigmoid_rr_pick, shall implement the round-robin pick: inputs are the request vector and pointer; outputs are a one-hot grant and an any flag. All pipeline logic stays in the top.

Verification
REQ-028 Single-operand results, checked with rsp_ready=1:
- requester 2 sends x=0: at N+2, rsp_data=128 and rsp_id=2;
- x=32 gives 224;
- x=-32 gives 32.
REQ-029 Saturation, checked in turn:
- x=64 gives 256;
- x=127 gives 256;
- x=-64 gives 0;
- x=-128 gives 0.
REQ-030 Round-robin order: with all 4 req_valid held high and rsp_ready=1, the grant order shall be 0,1,2,3,0 over 5 cycles, with results arriving back-to-back.
REQ-031 Backpressure:
- hold rsp_ready=0 for 5 cycles with requesters active; rsp_data stays stable and at most 2 grants occur;
- release rsp_ready; no result is lost or duplicated.
REQ-032 Reset with S1 and S2 full:
- pulse rst for one cycle; outputs read 0 the next cycle and xfer_count=0;
- requester 3 alone is then granted first.
REQ-033 Counter wrap: preload xfer_count to 0xFFFF by force, then complete one transfer; xfer_count shall read 0.
